register_dump_unit: RTL and testbench
=====================================

Name: register_dump_unit

Overview:
- Debug-side reader for the register bank's debug read port: while the pipeline is halted, it walks register addresses 0..N_REGS-1, samples each 32-bit value and serialises it as bytes to the UART transmitter.
- Sits between the debug unit command decoder (start request), the decode stage (o_r_addr drives the bank read address during halt, i_r_data is the bank read data) and the UART TX (start/done handshake).

Parameters:
NB_DATA, 32, width of a register value (must be a multiple of 8)
NB_ADDR, 5, register address width
N_REGS, 32, number of registers dumped (addresses 0..N_REGS-1)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  dump request, sampled only in IDLE
i_halted  in  1  pipeline halted; must stay high for the whole dump
o_r_addr  out  NB_ADDR  register bank debug read address
i_r_data  in  NB_DATA  register bank debug read data, combinational from o_r_addr
o_tx_data  out  8  byte to transmit
o_tx_start  out  1  one-cycle request to UART TX
i_tx_done  in  1  UART TX finished current byte (one-cycle pulse)
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse: all registers sent
o_abort  out  1  one-cycle pulse: dump aborted because i_halted fell

Behaviour:
- Reset (i_reset_n=0, asynchronous): state IDLE; o_r_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0, o_abort=0; shift register and byte counter cleared. Takes effect immediately with no clock edge, including mid-dump.
- FSM states: IDLE, SET_ADDR, LATCH, SEND, WAIT, NEXT, DONE.
- IDLE:
  - o_busy=0.
  - i_start=1 and i_halted=1 -> SET_ADDR with o_r_addr=0.
  - i_start while i_halted=0 is ignored.
- SET_ADDR: one cycle for the address to settle -> LATCH.
- LATCH: shift <= i_r_data; byte_cnt <= 0 -> SEND.
- SEND:
  - o_tx_data <= shift[7:0], registered and held through WAIT.
  - o_tx_start=1 for exactly this one cycle -> WAIT.
  - i_tx_done in SEND is ignored.
- WAIT: hold until i_tx_done=1, then:
  - shift >>= 8 and byte_cnt++.
  - If the byte just sent was byte NB_DATA/8-1 -> NEXT, else -> SEND.
- NEXT:
  - o_r_addr==N_REGS-1 -> DONE.
  - Else o_r_addr++ -> SET_ADDR.
- DONE: o_done=1 for one cycle; o_r_addr <= 0 -> IDLE.
- o_busy=1 in every state except IDLE.
- Byte order: register 0 first, ascending; within a register, LSB byte first. A full dump is N_REGS*NB_DATA/8 bytes (128 with the defaults).
- Latency: i_start sampled at edge k -> o_tx_start high in the cycle after edge k+2. Between bytes of one register, the next o_tx_start is 1 cycle after i_tx_done. Between registers, it is 4 cycles after i_tx_done (NEXT, SET_ADDR, LATCH, SEND).
- Abort: in any non-IDLE state except DONE, if i_halted=0:
  - Go to IDLE next cycle with o_abort=1 for one cycle.
  - o_r_addr=0, o_tx_start=0, o_done not asserted.
  - A byte already handed to the TX is not recalled.
- i_start while busy is ignored and does not restart the dump.
- i_tx_done while IDLE is ignored.
- o_r_addr never exceeds N_REGS-1.

Test Plan:
- Bank model i_r_data = 32'hA0B0C000 | addr, i_halted=1, TX model returns i_tx_done 3 cycles after each o_tx_start, pulse i_start -> exactly 128 o_tx_start pulses. First bytes 0x00,0xC0,0xB0,0xA0; last bytes 0x1F,0xC0,0xB0,0xA0. One o_done pulse after the last i_tx_done; o_busy then 0; o_r_addr=0.
- i_start=1 with i_halted=0 for 5 cycles -> no o_tx_start, o_busy stays 0, o_r_addr stays 0.
- Drop i_halted after the 10th i_tx_done -> o_abort pulses once, o_busy=0 next cycle, no o_done, no further o_tx_start. A fresh i_start with halted restarts at register 0 byte 0x00.
- Random i_tx_done delay 0..20 cycles plus spurious i_tx_done pulses during SEND and IDLE -> byte stream identical to scenario 1, no duplicated or skipped bytes.
- Assert i_reset_n=0 between clock edges during register 7 -> all outputs 0 before the next edge. After release, i_start dumps from register 0.
- Pulse i_start repeatedly during a dump -> still exactly 128 bytes and one o_done.

Source files
------------

// File: rtl/register_dump_unit_if.sv
// ---------------------------------------------------------------------------
// register_dump_unit_if
//   Bundles the signals between the register dump unit and its neighbours:
//   the debug command decoder (start/halted), the register bank debug read
//   port (address/data), the UART transmitter (byte/start/done) and the dump
//   status flags.
//
//   Signals:
//     i_start     dump request from the debug command decoder
//     i_halted    pipeline halted indication
//     o_r_addr    register bank debug read address
//     i_r_data    register bank debug read data (combinational from o_r_addr)
//     o_tx_data   byte presented to the UART transmitter
//     o_tx_start  one-cycle transmit request
//     i_tx_done   one-cycle pulse from the UART: current byte finished
//     o_busy      dump in progress
//     o_done      one-cycle pulse: every register has been sent
//     o_abort     one-cycle pulse: dump abandoned because the halt was lost
//
//   Modports:
//     master  the dump unit itself (drives the o_* signals)
//     slave   the surrounding logic (drives the i_* signals)
// ---------------------------------------------------------------------------
interface register_dump_unit_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
);
    logic                i_start;
    logic                i_halted;
    logic [NB_ADDR-1:0]  o_r_addr;
    logic [NB_DATA-1:0]  i_r_data;
    logic [7:0]          o_tx_data;
    logic                o_tx_start;
    logic                i_tx_done;
    logic                o_busy;
    logic                o_done;
    logic                o_abort;

    modport master (
        input  i_start,
        input  i_halted,
        input  i_r_data,
        input  i_tx_done,
        output o_r_addr,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_done,
        output o_abort
    );

    modport slave (
        output i_start,
        output i_halted,
        output i_r_data,
        output i_tx_done,
        input  o_r_addr,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_done,
        input  o_abort
    );
endinterface

// File: rtl/register_dump_unit.sv
// ---------------------------------------------------------------------------
// register_dump_unit
//   Debug-side reader of the register bank. While the pipeline is halted it
//   walks register addresses 0..N_REGS-1, samples each NB_DATA-bit value and
//   hands it to the UART transmitter one byte at a time, least significant
//   byte first, register 0 first.
//
//   Ports:
//     i_clk      system clock
//     i_reset_n  asynchronous active-low reset
//     dbg        register_dump_unit_if.master
//                  start/halted from the debug command decoder,
//                  r_addr/r_data to/from the register bank debug port,
//                  tx_data/tx_start/tx_done with the UART transmitter,
//                  busy/done/abort status
//
//   State table:
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     IDLE      | waiting for a start request while halted
//     SET_ADDR  | read address driven, bank output settling
//     LATCH     | capture register value into the shift register
//     SEND      | tx_start high for one cycle, byte presented on tx_data
//     WAIT      | waiting for the UART to finish the byte
//     NEXT      | advance to the next register or finish
//     DONE      | one-cycle done pulse, address returned to 0
// ---------------------------------------------------------------------------
module register_dump_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    register_dump_unit_if.master  dbg
);

    localparam int                 NB_BYTES  = NB_DATA / 8;
    localparam int                 NB_CNT    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_ADDR,
        ST_LATCH,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [NB_ADDR-1:0]   r_addr_q;
    logic [NB_ADDR-1:0]   r_addr_next;
    logic [NB_DATA-1:0]   shift_q;
    logic [NB_DATA-1:0]   shift_next;
    logic [NB_CNT-1:0]    byte_cnt_q;
    logic [NB_CNT-1:0]    byte_cnt_next;
    logic [7:0]           tx_data_q;
    logic [7:0]           tx_data_next;
    logic                 abort_q;
    logic                 abort_next;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr_q   <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
            abort_q    <= 1'b0;
        end else begin
            r_addr_q   <= r_addr_next;
            shift_q    <= shift_next;
            byte_cnt_q <= byte_cnt_next;
            tx_data_q  <= tx_data_next;
            abort_q    <= abort_next;
        end
    end

    always_comb begin
        state_next    = state;
        r_addr_next   = r_addr_q;
        shift_next    = shift_q;
        byte_cnt_next = byte_cnt_q;
        tx_data_next  = tx_data_q;
        abort_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dbg.i_start && dbg.i_halted) begin
                    r_addr_next = '0;
                    state_next  = ST_SET_ADDR;
                end
            end

            ST_SET_ADDR: begin
                state_next = ST_LATCH;
            end

            // The outgoing byte register is loaded on entry to SEND so the
            // UART sees valid data in the same cycle as tx_start; it then
            // holds through WAIT.
            ST_LATCH: begin
                shift_next    = dbg.i_r_data;
                byte_cnt_next = '0;
                tx_data_next  = dbg.i_r_data[7:0];
                state_next    = ST_SEND;
            end

            ST_SEND: begin
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (dbg.i_tx_done) begin
                    shift_next    = shift_q >> 8;
                    byte_cnt_next = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_next = ST_NEXT;
                    end else begin
                        tx_data_next = shift_next[7:0];
                        state_next   = ST_SEND;
                    end
                end
            end

            ST_NEXT: begin
                if (r_addr_q == LAST_ADDR) begin
                    state_next = ST_DONE;
                end else begin
                    r_addr_next = r_addr_q + 1'b1;
                    state_next  = ST_SET_ADDR;
                end
            end

            ST_DONE: begin
                r_addr_next = '0;
                state_next  = ST_IDLE;
            end

            default: begin
                r_addr_next = '0;
                state_next  = ST_IDLE;
            end
        endcase

        // Losing the halt mid-dump wins over any other transition. DONE is
        // excluded: the dump is already complete at that point.
        if ((state != ST_IDLE) && (state != ST_DONE) && !dbg.i_halted) begin
            state_next  = ST_IDLE;
            r_addr_next = '0;
            abort_next  = 1'b1;
        end
    end

    assign dbg.o_r_addr   = r_addr_q;
    assign dbg.o_tx_data  = tx_data_q;
    assign dbg.o_tx_start = (state == ST_SEND);
    assign dbg.o_busy     = (state != ST_IDLE);
    assign dbg.o_done     = (state == ST_DONE);
    assign dbg.o_abort    = abort_q;

endmodule

// File: tb/tb_register_dump_unit.sv
module tb_register_dump_unit;

    localparam int NB_DATA   = 32;
    localparam int NB_ADDR   = 5;
    localparam int N_REGS    = 32;
    localparam int NB_BYTES  = NB_DATA / 8;
    localparam int DUMP_LEN  = N_REGS * NB_BYTES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    register_dump_unit_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dbg();

    register_dump_unit #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .N_REGS  (N_REGS)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .dbg       (dbg)
    );

    // Register bank model: each register reads back as A0B0C000 | address.
    assign dbg.i_r_data = 32'hA0B0C000 | 32'(dbg.o_r_addr);

    always #5 clk = ~clk;

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_tx    = 0;
    int         n_done  = 0;
    int         n_abort = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    bit         tx_rand = 1'b0;
    bit         spur_en = 1'b0;
    int         tx_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected byte stream of one complete dump.
    task automatic push_dump();
        logic [31:0] val;
        for (int r = 0; r < N_REGS; r++) begin
            val = 32'hA0B0C000 | 32'(r);
            for (int b = 0; b < NB_BYTES; b++) begin
                exp_q.push_back(8'((val >> (8 * b)) & 32'hFF));
            end
        end
    endtask

    // Monitor / scoreboard: every transmit request pops one expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dbg.o_tx_start) begin
                n_tx++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_byte: unexpected o_tx_start with byte %0h, required no request", dbg.o_tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("tx_byte", 32'(dbg.o_tx_data), 32'(exp_byte));
                end
            end
            if (dbg.o_done)  n_done++;
            if (dbg.o_abort) n_abort++;
        end
    end

    // UART TX model: done pulse a fixed 3 cycles (or a random 1..21 cycles)
    // after each request, with optional stray pulses during SEND and IDLE.
    initial begin
        bit tx_v;
        dbg.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_v = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_v = 1'b1;
            end
            if (rst_n && dbg.o_tx_start) begin
                tx_cnt = (tx_rand ? int'($urandom_range(20, 0)) : 2) + 1;
                if (spur_en && ($urandom_range(1, 0) == 1)) tx_v = 1'b1;
            end
            if (!dbg.o_busy && spur_en && ($urandom_range(2, 0) == 0)) tx_v = 1'b1;
            dbg.i_tx_done = tx_v;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        dbg.i_start = 1'b1;
        @(negedge clk);
        dbg.i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dbg.o_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic finish_dump(input string name, input int tx0, input int done0);
        wait_done({name, "_done_seen"}, 4000);
        @(negedge clk);
        check({name, "_busy_after"},  32'(dbg.o_busy), 32'd0);
        check({name, "_addr_after"},  32'(dbg.o_r_addr), 32'd0);
        check({name, "_done_width"},  32'(dbg.o_done), 32'd0);
        check({name, "_byte_count"},  32'(n_tx - tx0), 32'(DUMP_LEN));
        check({name, "_done_count"},  32'(n_done - done0), 32'd1);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic full_dump(input string name);
        int tx0, done0;
        tx0   = n_tx;
        done0 = n_done;
        push_dump();
        pulse_start();
        finish_dump(name, tx0, done0);
    endtask

    initial begin
        int tx0, done0, abort0, seen;
        bit hit;

        dbg.i_start  = 1'b0;
        dbg.i_halted = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(dbg.o_busy), 32'd0);
        check("rst_tx_start", 32'(dbg.o_tx_start), 32'd0);
        check("rst_done",     32'(dbg.o_done), 32'd0);
        check("rst_abort",    32'(dbg.o_abort), 32'd0);
        check("rst_addr",     32'(dbg.o_r_addr), 32'd0);
        check("rst_tx_data",  32'(dbg.o_tx_data), 32'd0);
        rst_n = 1'b1;
        dbg.i_halted = 1'b1;
        repeat (3) @(negedge clk);

        // Full dump with fixed TX latency, plus start-to-first-byte latency
        tx0   = n_tx;
        done0 = n_done;
        push_dump();
        @(negedge clk);
        dbg.i_start = 1'b1;
        @(negedge clk);
        dbg.i_start = 1'b0;
        check("lat_cycle1", 32'(dbg.o_tx_start), 32'd0);
        check("lat_busy",   32'(dbg.o_busy), 32'd1);
        @(negedge clk);
        check("lat_cycle2", 32'(dbg.o_tx_start), 32'd0);
        @(negedge clk);
        check("lat_cycle3", 32'(dbg.o_tx_start), 32'd1);
        finish_dump("dump1", tx0, done0);

        // Start request while not halted is ignored
        dbg.i_halted = 1'b0;
        dbg.i_start  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nohalt_busy",  32'(dbg.o_busy), 32'd0);
            check("nohalt_start", 32'(dbg.o_tx_start), 32'd0);
            check("nohalt_addr",  32'(dbg.o_r_addr), 32'd0);
        end
        dbg.i_start  = 1'b0;
        dbg.i_halted = 1'b1;
        repeat (2) @(negedge clk);

        // Abort after the 10th completed byte
        tx0    = n_tx;
        done0  = n_done;
        abort0 = n_abort;
        push_dump();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 2000 && seen < 10; i++) begin
            @(posedge clk);
            if (dbg.i_tx_done) seen++;
        end
        check("abort_reach10", 32'(seen), 32'd10);
        @(negedge clk);
        check("abort_byte10_start", 32'(dbg.o_tx_start), 32'd1);
        dbg.i_halted = 1'b0;
        @(negedge clk);
        check("abort_pulse",    32'(dbg.o_abort), 32'd1);
        check("abort_busy",     32'(dbg.o_busy), 32'd0);
        check("abort_tx_start", 32'(dbg.o_tx_start), 32'd0);
        check("abort_addr",     32'(dbg.o_r_addr), 32'd0);
        check("abort_no_done",  32'(dbg.o_done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("abort_width", 32'(dbg.o_abort), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_bytes_sent", 32'(n_tx - tx0), 32'd11);
        check("abort_done_count", 32'(n_done - done0), 32'd0);
        check("abort_count",      32'(n_abort - abort0), 32'd1);
        dbg.i_halted = 1'b1;
        repeat (2) @(negedge clk);
        full_dump("restart");

        // Random TX latency with stray done pulses in SEND and IDLE
        tx_rand = 1'b1;
        spur_en = 1'b1;
        repeat (10) @(negedge clk);
        full_dump("random");
        spur_en = 1'b0;
        repeat (25) @(negedge clk);
        tx_rand = 1'b0;

        // Asynchronous reset while register 7 is being sent
        push_dump();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (dbg.o_r_addr == NB_ADDR'(7)) hit = 1'b1;
        end
        check("rst_mid_reach_reg7", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy",     32'(dbg.o_busy), 32'd0);
        check("rstmid_tx_start", 32'(dbg.o_tx_start), 32'd0);
        check("rstmid_done",     32'(dbg.o_done), 32'd0);
        check("rstmid_abort",    32'(dbg.o_abort), 32'd0);
        check("rstmid_addr",     32'(dbg.o_r_addr), 32'd0);
        check("rstmid_tx_data",  32'(dbg.o_tx_data), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tx0 = n_tx;
        repeat (30) @(negedge clk);
        check("rstmid_quiet", 32'(n_tx - tx0), 32'd0);
        full_dump("after_reset");

        // Repeated start requests during a dump do not restart it
        repeat (5) @(negedge clk);
        tx0   = n_tx;
        done0 = n_done;
        push_dump();
        @(negedge clk);
        dbg.i_start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dbg.i_start = 1'($urandom_range(1, 0));
        end
        dbg.i_start = 1'b0;
        finish_dump("restart_spam", tx0, done0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
